// File: rtl/intersection_scheduler.sv
// Two-way intersection sequencer with latched crossing requests, min/max green and flashing-yellow fallback.
// Lamps are registered and decoded from the next state, so they change on the same cycle as phase; no backpressure.
module intersection_scheduler #(
  parameter int TICK_DIV     = 10,
  parameter int MIN_GREEN_MS = 5000,
  parameter int MAX_GREEN_MS = 20000,
  parameter int YELLOW_MS    = 2000,
  parameter int ALLRED_MS    = 1000,
  parameter int FLASH_MS     = 500
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic       req_a,
  input  logic       req_b,
  output logic       green_a,
  output logic       yellow_a,
  output logic       red_a,
  output logic       green_b,
  output logic       yellow_b,
  output logic       red_b,
  output logic [2:0] phase,
  output logic       pend_a,
  output logic       pend_b
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] MIN_G   = 16'(MIN_GREEN_MS);
  localparam logic [15:0] MAX_G   = 16'(MAX_GREEN_MS);
  localparam logic [15:0] YEL     = 16'(YELLOW_MS);
  localparam logic [15:0] ALLRED  = 16'(ALLRED_MS);
  localparam logic [15:0] FL_LAST = 16'(FLASH_MS - 1);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    FLASH = 3'd6
  } state_t;

  state_t        state, nxt;
  logic [PW-1:0] presc;
  logic [15:0]   ms, ms_nxt, fcnt;
  logic          tick, fwrap, chg, flash_yel;
  logic          pa_nxt, pb_nxt, fy_nxt;

  assign phase = state;

  // Exit tests use the post-increment ms value so a D-ms state lasts exactly D*TICK_DIV cycles.
  assign tick   = (presc == PRESC_LAST);
  assign ms_nxt = (tick && ms != 16'hFFFF) ? ms + 16'd1 : ms;
  assign fwrap  = tick && (fcnt == FL_LAST);
  assign chg    = (nxt != state);

  always_comb begin
    nxt = state;
    if (!en) begin
      nxt = FLASH;
    end else begin
      case (state)
        A_GRN: if (ms_nxt >= MAX_G || (ms_nxt >= MIN_G && pend_b)) nxt = A_YEL;
        A_YEL: if (ms_nxt == YEL)    nxt = AR_AB;
        AR_AB: if (ms_nxt == ALLRED) nxt = B_GRN;
        B_GRN: if (ms_nxt >= MAX_G || (ms_nxt >= MIN_G && pend_a)) nxt = B_YEL;
        B_YEL: if (ms_nxt == YEL)    nxt = AR_BA;
        AR_BA: if (ms_nxt == ALLRED) nxt = A_GRN;
        default: nxt = AR_BA;
      endcase
    end
  end

  always_comb begin
    pa_nxt = pend_a;
    if (req_a && state != A_GRN) pa_nxt = 1'b1;
    if (nxt == A_GRN && state != A_GRN) pa_nxt = 1'b0;
    pb_nxt = pend_b;
    if (req_b && state != B_GRN) pb_nxt = 1'b1;
    if (nxt == B_GRN && state != B_GRN) pb_nxt = 1'b0;
    fy_nxt = flash_yel;
    if (chg) fy_nxt = 1'b1;
    else if (state == FLASH && fwrap) fy_nxt = ~flash_yel;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= AR_BA;
      presc     <= '0;
      ms        <= '0;
      fcnt      <= '0;
      flash_yel <= 1'b1;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      green_a   <= 1'b0;
      yellow_a  <= 1'b0;
      red_a     <= 1'b1;
      green_b   <= 1'b0;
      yellow_b  <= 1'b0;
      red_b     <= 1'b1;
    end else begin
      state     <= nxt;
      pend_a    <= pa_nxt;
      pend_b    <= pb_nxt;
      flash_yel <= fy_nxt;
      if (chg) begin
        presc <= '0;
        ms    <= '0;
        fcnt  <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        ms    <= ms_nxt;
        if (tick) fcnt <= fwrap ? 16'd0 : fcnt + 16'd1;
      end
      green_a  <= (nxt == A_GRN);
      yellow_a <= (nxt == A_YEL) || (nxt == FLASH && fy_nxt);
      red_a    <= (nxt == AR_AB) || (nxt == AR_BA) || (nxt == B_GRN) || (nxt == B_YEL);
      green_b  <= (nxt == B_GRN);
      yellow_b <= (nxt == B_YEL) || (nxt == FLASH && fy_nxt);
      red_b    <= (nxt == AR_AB) || (nxt == AR_BA) || (nxt == A_GRN) || (nxt == A_YEL);
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench: cycle-count reference model of the intersection sequence, directed scenarios then random traffic.
module tb_intersection_scheduler;

  localparam int T    = 2;
  localparam int MING = 4;
  localparam int MAXG = 10;
  localparam int YELM = 2;
  localparam int ARM  = 1;
  localparam int FLM  = 3;

  logic       CLK = 1'b0;
  logic       reset, en, req_a, req_b;
  logic       green_a, yellow_a, red_a, green_b, yellow_b, red_b;
  logic [2:0] phase;
  logic       pend_a, pend_b;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: phase plus number of whole cycles spent in it.
  int m_ph, m_cyc;
  bit m_pa, m_pb;

  intersection_scheduler #(
    .TICK_DIV(T), .MIN_GREEN_MS(MING), .MAX_GREEN_MS(MAXG),
    .YELLOW_MS(YELM), .ALLRED_MS(ARM), .FLASH_MS(FLM)
  ) dut (
    .CLK(CLK), .reset(reset), .en(en), .req_a(req_a), .req_b(req_b),
    .green_a(green_a), .yellow_a(yellow_a), .red_a(red_a),
    .green_b(green_b), .yellow_b(yellow_b), .red_b(red_b),
    .phase(phase), .pend_a(pend_a), .pend_b(pend_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int exp_lamps(input int ph, input int cyc);
    case (ph)
      0: return 6'b100_001;
      1: return 6'b010_001;
      2: return 6'b001_001;
      3: return 6'b001_100;
      4: return 6'b001_010;
      5: return 6'b001_001;
      default: return (((cyc / (FLM * T)) % 2) == 0) ? 6'b010_010 : 6'b000_000;
    endcase
  endfunction

  task automatic model_update();
    int  nph;
    bit  pa, pb;
    if (reset) begin
      m_ph = 5; m_cyc = 0; m_pa = 0; m_pb = 0;
      return;
    end
    nph = m_ph;
    if (!en) nph = 6;
    else case (m_ph)
      0: if (m_cyc + 1 >= MAXG * T || (m_pb && m_cyc + 1 >= MING * T)) nph = 1;
      1: if (m_cyc + 1 == YELM * T) nph = 2;
      2: if (m_cyc + 1 == ARM * T)  nph = 3;
      3: if (m_cyc + 1 >= MAXG * T || (m_pa && m_cyc + 1 >= MING * T)) nph = 4;
      4: if (m_cyc + 1 == YELM * T) nph = 5;
      5: if (m_cyc + 1 == ARM * T)  nph = 0;
      default: nph = 5;
    endcase
    pa = m_pa; pb = m_pb;
    if (req_a && m_ph != 0) pa = 1;
    if (req_b && m_ph != 3) pb = 1;
    if (nph == 0 && m_ph != 0) pa = 0;
    if (nph == 3 && m_ph != 3) pb = 0;
    m_pa = pa; m_pb = pb;
    m_cyc = (nph != m_ph) ? 0 : m_cyc + 1;
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("phase", int'(phase), m_ph);
    chk("pend", int'({pend_a, pend_b}), int'({m_pa, m_pb}));
    chk("lamps", int'({green_a, yellow_a, red_a, green_b, yellow_b, red_b}), exp_lamps(m_ph, m_cyc));
    chk("no_dual_green", int'(green_a & green_b), 0);
    if (m_ph != 6) begin
      chk("onehot_a", $countones({green_a, yellow_a, red_a}), 1);
      chk("onehot_b", $countones({green_b, yellow_b, red_b}), 1);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic run_until(input int ph, input int cyc, input int budget);
    int n = 0;
    while (!(int'(phase) == ph && m_cyc == cyc) && n < budget) begin
      step();
      n++;
    end
    chk("reach_phase", int'(phase), ph);
  endtask

  initial begin
    int n;
    reset = 1'b1; en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    step(); step();
    chk("rst_phase", int'(phase), 5);
    chk("rst_reds", int'({red_a, red_b, green_a, green_b, yellow_a, yellow_b}), 6'b110000);
    reset = 1'b0;

    // Free-running full cycle with no requests.
    for (int i = 0; i < 110; i++) step();

    // Short request pulse early in A green: green ends at the minimum.
    run_until(0, 2, 200);
    req_b = 1'b1; step(); req_b = 1'b0;
    chk("pend_b_set", int'(pend_b), 1);
    n = 1;
    while (phase == 3'd0 && n < 50) begin step(); n++; end
    chk("min_green_len", n, 6);
    run_until(3, 0, 50);
    chk("pend_b_clr", int'(pend_b), 0);

    // Request past the minimum ends green almost immediately; own-side request ignored.
    run_until(0, 0, 200);
    req_a = 1'b1;
    run_until(0, 12, 50);
    req_b = 1'b1; step(); req_b = 1'b0; req_a = 1'b0;
    chk("pend_a_ignored", int'(pend_a), 0);
    step();
    chk("yel_after_req", int'(phase), 1);

    // Disable mid B yellow: flashing yellow, then re-enable.
    run_until(4, 1, 200);
    en = 1'b0; step();
    chk("flash_phase", int'(phase), 6);
    chk("flash_lamps_on", int'({yellow_a, yellow_b, red_a, red_b, green_a, green_b}), 6'b110000);
    for (int i = 0; i < 6; i++) step();
    chk("flash_off", int'({yellow_a, yellow_b}), 0);
    for (int i = 0; i < 6; i++) step();
    chk("flash_on_again", int'({yellow_a, yellow_b}), 3);
    en = 1'b1; step();
    chk("reenable_allred", int'(phase), 5);
    run_until(0, 0, 4);

    // Reset mid B green with A pending.
    run_until(1, 0, 200);
    req_a = 1'b1; step(); req_a = 1'b0;
    run_until(3, 5, 50);
    chk("pend_a_before_rst", int'(pend_a), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_phase", int'(phase), 5);
    chk("midrst_reds", int'({red_a, red_b}), 3);
    chk("midrst_pend_a", int'(pend_a), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      req_a = ($urandom_range(0, 15) == 0);
      req_b = ($urandom_range(0, 15) == 0);
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 29) == 0) en = 1'b1;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
